// File: rtl/bin_to_bcd_seq_pkg.sv
// Shared constants for the sequential binary-to-BCD converter: digit width,
// internal digit count and FSM state encodings.
package bin_to_bcd_seq_pkg;

    localparam int BCD_W = 4;

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] SHIFT = 2'd1;
    localparam logic [1:0] DONE  = 2'd2;

    // Enough decimal digits to hold 2^width-1.
    function automatic int idig_f(input int width);
        return (width + 2) / 3;
    endfunction

endpackage

// File: rtl/bcd_add3.sv
// Double-dabble digit corrector: adds 3 to a BCD digit of 5 or more so the
// following left shift carries correctly into the next decade.
module bcd_add3 (
    input  logic [3:0] din,
    output logic [3:0] dout
);

    always_comb begin
        dout = (din >= 4'd5) ? din + 4'd3 : din;
    end

endmodule

// File: rtl/bin_to_bcd_seq.sv
// Sequential shift-and-add-3 binary-to-BCD converter, one input bit per clock,
// with start/busy/done handshake, overflow saturation and leading-zero blanking.
module bin_to_bcd_seq
    import bin_to_bcd_seq_pkg::*;
#(
    parameter int WIDTH  = 10,
    parameter int DIGITS = 3
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic [WIDTH-1:0]        binary,
    output logic                    ready,
    output logic                    busy,
    output logic                    done,
    output logic [BCD_W*DIGITS-1:0] bcd,
    output logic                    overflow,
    output logic [DIGITS-1:0]       blank
);

    localparam int IDIG = idig_f(WIDTH);
    localparam int SW   = BCD_W * IDIG + WIDTH;
    localparam int CW   = $clog2(WIDTH + 1);
    localparam int ODIG = (IDIG > DIGITS) ? IDIG : DIGITS;

    localparam logic [DIGITS-1:0] BLANK_RST = ~DIGITS'(1);

    logic [1:0]              state_q, state_d;
    logic [SW-1:0]           scratch_q, scratch_d;
    logic [CW-1:0]           cnt_q, cnt_d;
    logic [BCD_W*IDIG-1:0]   digits_adj;
    logic [SW-1:0]           corrected, shifted;
    logic                    load, finish;

    logic [BCD_W*ODIG-1:0]   res_digits;
    logic                    ovf_c;
    logic [BCD_W*DIGITS-1:0] bcd_c;
    logic [DIGITS-1:0]       blank_c;
    logic                    zero_run;

    logic [BCD_W*DIGITS-1:0] bcd_q;
    logic                    overflow_q, done_q;
    logic [DIGITS-1:0]       blank_q;

    for (genvar i = 0; i < IDIG; i++) begin : g_add3
        bcd_add3 u_add3 (
            .din  (scratch_q[WIDTH+BCD_W*i +: BCD_W]),
            .dout (digits_adj[BCD_W*i +: BCD_W])
        );
    end

    assign corrected = {digits_adj, scratch_q[WIDTH-1:0]};
    assign shifted   = {corrected[SW-2:0], 1'b0};
    assign finish    = (state_q == SHIFT) && (cnt_q == CW'(1));

    always_comb begin
        state_d   = state_q;
        scratch_d = scratch_q;
        cnt_d     = cnt_q;
        load      = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = SHIFT;
                    load    = 1'b1;
                end
            end
            SHIFT: begin
                scratch_d = shifted;
                cnt_d     = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (start) begin
                    state_d = SHIFT;
                    load    = 1'b1;
                end else begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        if (load) begin
            scratch_d = {{(SW-WIDTH){1'b0}}, binary};
            cnt_d     = CW'(WIDTH);
        end
    end

    // Final result is taken from the last shift so it lands in the DONE cycle.
    always_comb begin
        res_digits                   = '0;
        res_digits[BCD_W*IDIG-1:0]   = shifted[SW-1:WIDTH];
        ovf_c                        = 1'b0;
        for (int k = DIGITS; k < ODIG; k++) begin
            if (res_digits[BCD_W*k +: BCD_W] != '0) begin
                ovf_c = 1'b1;
            end
        end
        bcd_c = ovf_c ? {DIGITS{4'h9}} : res_digits[BCD_W*DIGITS-1:0];

        blank_c  = '0;
        zero_run = 1'b1;
        for (int k = DIGITS - 1; k >= 1; k--) begin
            zero_run   = zero_run && (bcd_c[BCD_W*k +: BCD_W] == '0);
            blank_c[k] = zero_run;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            scratch_q  <= '0;
            cnt_q      <= '0;
            bcd_q      <= '0;
            overflow_q <= 1'b0;
            blank_q    <= BLANK_RST;
            done_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            scratch_q <= scratch_d;
            cnt_q     <= cnt_d;
            done_q    <= finish;
            if (finish) begin
                bcd_q      <= bcd_c;
                overflow_q <= ovf_c;
                blank_q    <= blank_c;
            end
        end
    end

    assign bcd      = bcd_q;
    assign overflow = overflow_q;
    assign blank    = blank_q;
    assign done     = done_q;
    assign busy     = (state_q == SHIFT);
    assign ready    = (state_q != SHIFT);

endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// Self-checking bench for bin_to_bcd_seq: vector table, handshake corner cases,
// full 10-bit sweep and a randomized 16-bit/5-digit instance against a decimal model.
module tb_bin_to_bcd_seq;

    logic        clk;
    logic        rst;

    logic        start_a;
    logic [9:0]  bin_a;
    logic        ready_a, busy_a, done_a, ovf_a;
    logic [11:0] bcd_a;
    logic [2:0]  blank_a;

    logic        start_b;
    logic [15:0] bin_b;
    logic        ready_b, busy_b, done_b, ovf_b;
    logic [19:0] bcd_b;
    logic [4:0]  blank_b;

    int n_checks;
    int n_fail;

    bin_to_bcd_seq #(.WIDTH(10), .DIGITS(3)) u_dut_a (
        .clk      (clk),
        .rst      (rst),
        .start    (start_a),
        .binary   (bin_a),
        .ready    (ready_a),
        .busy     (busy_a),
        .done     (done_a),
        .bcd      (bcd_a),
        .overflow (ovf_a),
        .blank    (blank_a)
    );

    bin_to_bcd_seq #(.WIDTH(16), .DIGITS(5)) u_dut_b (
        .clk      (clk),
        .rst      (rst),
        .start    (start_b),
        .binary   (bin_b),
        .ready    (ready_b),
        .busy     (busy_b),
        .done     (done_b),
        .bcd      (bcd_b),
        .overflow (ovf_b),
        .blank    (blank_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Decimal reference: digits by division, overflow and blanking by magnitude.
    function automatic void model(input longint v, input int digits, output logic [31:0] bcd,
                                  output logic ovf, output logic [7:0] blank);
        longint p;
        p = 1;
        for (int k = 0; k < digits; k++) p = p * 10;
        ovf   = (v >= p);
        bcd   = '0;
        blank = '0;
        p     = 1;
        for (int k = 0; k < digits; k++) begin
            bcd[4*k +: 4] = ovf ? 4'd9 : 4'((v / p) % 10);
            if (k > 0) blank[k] = !ovf && (v < p);
            p = p * 10;
        end
    endfunction

    // Called just after a negedge with the DUT ready; returns at the negedge showing done.
    task automatic run_a(input logic [9:0] v, output int lat);
        start_a = 1'b1;
        bin_a   = v;
        lat     = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            lat++;
            start_a = 1'b0;
            bin_a   = 10'($urandom);
            if (done_a) break;
        end
        if (!done_a) check("timeout_a", 32'(lat), 32'd11);
    endtask

    task automatic run_b(input logic [15:0] v, output int lat);
        start_b = 1'b1;
        bin_b   = v;
        lat     = 0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            lat++;
            start_b = 1'b0;
            bin_b   = 16'($urandom);
            if (done_b) break;
        end
        if (!done_b) check("timeout_b", 32'(lat), 32'd17);
    endtask

    typedef struct {
        logic [9:0]  bin;
        logic [11:0] bcd;
        logic        ovf;
        logic [2:0]  blank;
    } vec_t;

    initial begin
        vec_t        vecs[8];
        int          lat;
        int          ndone;
        int          t0;
        logic [31:0] e_bcd;
        logic        e_ovf;
        logic [7:0]  e_blank;
        logic [15:0] rv;

        vecs[0] = '{10'd0,    12'h000, 1'b0, 3'b110};
        vecs[1] = '{10'd205,  12'h205, 1'b0, 3'b000};
        vecs[2] = '{10'd7,    12'h007, 1'b0, 3'b110};
        vecs[3] = '{10'd999,  12'h999, 1'b0, 3'b000};
        vecs[4] = '{10'd1000, 12'h999, 1'b1, 3'b000};
        vecs[5] = '{10'd1023, 12'h999, 1'b1, 3'b000};
        vecs[6] = '{10'd10,   12'h010, 1'b0, 3'b100};
        vecs[7] = '{10'd100,  12'h100, 1'b0, 3'b000};

        n_checks = 0;
        n_fail   = 0;
        rst      = 1'b1;
        start_a  = 1'b0;
        bin_a    = '0;
        start_b  = 1'b0;
        bin_b    = '0;
        repeat (3) @(negedge clk);
        check("rst_bcd", 32'(bcd_a), 32'h000);
        check("rst_ovf", 32'(ovf_a), 32'd0);
        check("rst_blank", 32'(blank_a), 32'b110);
        check("rst_done", 32'(done_a), 32'd0);
        check("rst_busy", 32'(busy_a), 32'd0);
        check("rst_ready", 32'(ready_a), 32'd1);
        check("rst_blank_b", 32'(blank_b), 32'b11110);
        rst = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 8; i++) begin
            run_a(vecs[i].bin, lat);
            check($sformatf("vec%0d_lat", i), 32'(lat), 32'd11);
            check($sformatf("vec%0d_bcd", i), 32'(bcd_a), 32'(vecs[i].bcd));
            check($sformatf("vec%0d_ovf", i), 32'(ovf_a), 32'(vecs[i].ovf));
            check($sformatf("vec%0d_blank", i), 32'(blank_a), 32'(vecs[i].blank));
        end
        @(negedge clk);
        check("hold_bcd", 32'(bcd_a), 32'h100);
        check("done_one_cycle", 32'(done_a), 32'd0);

        // Back-to-back with start held high: 42 then 517.
        start_a = 1'b1;
        bin_a   = 10'd42;
        @(negedge clk);
        check("b2b_busy", 32'(busy_a), 32'd1);
        check("b2b_ready", 32'(ready_a), 32'd0);
        bin_a = 10'd517;
        ndone = 0;
        t0    = 0;
        for (int i = 1; i < 40 && ndone < 2; i++) begin
            if (done_a) begin
                ndone++;
                if (ndone == 1) begin
                    t0 = i;
                    check("b2b_first", 32'(bcd_a), 32'h042);
                end else begin
                    start_a = 1'b0;
                    check("b2b_gap", 32'(i - t0), 32'd11);
                    check("b2b_second", 32'(bcd_a), 32'h517);
                end
            end
            if (ndone < 2) @(negedge clk);
        end
        start_a = 1'b0;
        check("b2b_count", 32'(ndone), 32'd2);
        @(negedge clk);

        // A start pulse mid-conversion must be ignored.
        start_a = 1'b1;
        bin_a   = 10'd300;
        @(negedge clk);
        start_a = 1'b0;
        repeat (4) @(negedge clk);
        start_a = 1'b1;
        bin_a   = 10'd1;
        @(negedge clk);
        start_a = 1'b0;
        check("mid_hold_bcd", 32'(bcd_a), 32'h517);
        ndone = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (done_a) begin
                ndone++;
                check("mid_result", 32'(bcd_a), 32'h300);
            end
        end
        check("mid_done_count", 32'(ndone), 32'd1);

        // Reset five cycles into a conversion aborts it.
        start_a = 1'b1;
        bin_a   = 10'd345;
        @(negedge clk);
        start_a = 1'b0;
        repeat (4) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("abort_bcd", 32'(bcd_a), 32'h000);
        check("abort_blank", 32'(blank_a), 32'b110);
        check("abort_busy", 32'(busy_a), 32'd0);
        check("abort_ready", 32'(ready_a), 32'd1);
        rst   = 1'b0;
        ndone = 0;
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            if (done_a) ndone++;
        end
        check("abort_no_done", 32'(ndone), 32'd0);
        run_a(10'd345, lat);
        check("after_abort", 32'(bcd_a), 32'h345);

        // Full sweep of the 10-bit input range.
        for (int v = 0; v < 1024; v++) begin
            run_a(10'(v), lat);
            model(longint'(v), 3, e_bcd, e_ovf, e_blank);
            check($sformatf("sweep%0d_bcd", v), 32'(bcd_a), 32'(e_bcd[11:0]));
            check($sformatf("sweep%0d_ovf", v), 32'(ovf_a), 32'(e_ovf));
            check($sformatf("sweep%0d_blank", v), 32'(blank_a), 32'(e_blank[2:0]));
        end

        // 16-bit, 5-digit instance: corners then random values.
        for (int i = 0; i < 204; i++) begin
            case (i)
                0:       rv = 16'd0;
                1:       rv = 16'd65535;
                2:       rv = 16'd10000;
                3:       rv = 16'd9;
                default: rv = 16'($urandom_range(0, 65535));
            endcase
            run_b(rv, lat);
            model(longint'(rv), 5, e_bcd, e_ovf, e_blank);
            if (i == 0) check("b_lat", 32'(lat), 32'd17);
            if (i == 1) check("b_65535", 32'(bcd_b), 32'h65535);
            check($sformatf("b%0d_bcd", rv), 32'(bcd_b), 32'(e_bcd[19:0]));
            check($sformatf("b%0d_ovf", rv), 32'(ovf_b), 32'(e_ovf));
            check($sformatf("b%0d_blank", rv), 32'(blank_b), 32'(e_blank[4:0]));
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
